// File: rtl/branch_pc_unit.sv
// -----------------------------------------------------------------------------
// branch_pc_unit
//
// Branch resolution and program counter register. It takes the comparison
// stage results for the current instruction, decides whether the instruction
// redirects, computes the next PC and issues a one-cycle flush after every
// taken redirect. A misaligned redirect target freezes the unit in a sticky
// fault state that only reset can clear.
//
// Optional feature (macro BRANCH_STATS_EN):
//   When defined, adds saturating taken / not-taken counters for the
//   conditional branches (beq, bne, blt, bge). When undefined, the counter
//   ports are absent and everything else behaves the same.
//
// Parameters:
//   RESET_PC  PC value loaded on reset.
//   COUNT_W   width of the branch statistics counters (BRANCH_STATS_EN only).
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   en             advance enable; 0 stalls and holds all state
//   br_type        000 none, 001 beq, 010 bne, 011 blt, 100 bge,
//                  101 j, 110 jal, 111 jr
//   cmp_ne         comparison difference; nonzero means operands differ
//   cmp_lt         set-less-than result; only bit 0 is significant
//   imm            branch offset in words (sign-extended)
//   jaddr          jump index field
//   jr_target      register target for jr
//   pc             current PC
//   pc_plus4       pc + 4 (jal link value)
//   taken          combinational; the current instruction redirects
//   flush          registered; discard the fetched instruction
//   fault          registered, sticky; a misaligned target was detected
//   taken_cnt      (BRANCH_STATS_EN) taken conditional branches, saturating
//   not_taken_cnt  (BRANCH_STATS_EN) not-taken conditional branches, saturating
// -----------------------------------------------------------------------------
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [2:0]         br_type,
  input  logic [31:0]        cmp_ne,
  input  logic [31:0]        cmp_lt,
  input  logic [15:0]        imm,
  input  logic [25:0]        jaddr,
  input  logic [31:0]        jr_target,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               taken,
  output logic               flush,
  output logic               fault
`ifdef BRANCH_STATS_EN
  ,
  output logic [COUNT_W-1:0] taken_cnt,
  output logic [COUNT_W-1:0] not_taken_cnt
`endif
);

  // Branch type encodings
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_J    = 3'b101;
  localparam logic [2:0] BR_JAL  = 3'b110;
  localparam logic [2:0] BR_JR   = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        flush_reg;
  logic        fault_reg;

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        cond_hit;   // the br_type condition is satisfied
  logic        is_cond;    // br_type is one of the four conditional branches
  logic        run_active; // a decision is actually made this cycle

  // ---------------------------------------------------------------------------
  // Target arithmetic. All sums wrap modulo 2^32; wrap-around is legal.
  // ---------------------------------------------------------------------------
  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign jump_target   = {pc_plus4[31:28], jaddr, 2'b00};

  // ---------------------------------------------------------------------------
  // Branch condition decode and target select
  // ---------------------------------------------------------------------------
  always_comb begin
    cond_hit = 1'b0;
    is_cond  = 1'b0;
    target   = branch_target;
    case (br_type)
      BR_NONE: cond_hit = 1'b0;
      BR_BEQ: begin
        is_cond  = 1'b1;
        cond_hit = (cmp_ne == 32'd0);
      end
      BR_BNE: begin
        is_cond  = 1'b1;
        cond_hit = (cmp_ne != 32'd0);
      end
      BR_BLT: begin
        is_cond  = 1'b1;
        cond_hit = cmp_lt[0];
      end
      BR_BGE: begin
        is_cond  = 1'b1;
        cond_hit = ~cmp_lt[0];
      end
      BR_J, BR_JAL: begin
        cond_hit = 1'b1;
        target   = jump_target;
      end
      BR_JR: begin
        cond_hit = 1'b1;
        target   = jr_target;
      end
      default: cond_hit = 1'b0;
    endcase
  end

  // Only a RUN cycle with en=1 decides; FLUSH squashes the instruction and
  // FAULT / stall cycles never redirect.
  assign run_active = (state_reg == ST_RUN) && en;
  assign taken      = run_active && cond_hit;

  // ---------------------------------------------------------------------------
  // PC / control FSM with registered flush and fault outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
      pc_reg    <= RESET_PC;
      flush_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (en) begin
            if (cond_hit) begin
              if (target[1:0] != 2'b00) begin
                // Misaligned redirect: PC stays on the offending instruction.
                state_reg <= ST_FAULT;
                fault_reg <= 1'b1;
                flush_reg <= 1'b0;
              end else begin
                pc_reg    <= target;
                state_reg <= ST_FLUSH;
                flush_reg <= 1'b1;
              end
            end else begin
              pc_reg <= pc_plus4;
            end
          end
        end
        ST_FLUSH: begin
          // The instruction fetched behind the redirect is squashed; its
          // br_type is ignored and the PC simply advances.
          if (en) begin
            pc_reg    <= pc_plus4;
            state_reg <= ST_RUN;
            flush_reg <= 1'b0;
          end
        end
        ST_FAULT: begin
          fault_reg <= 1'b1;
          flush_reg <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park in the safe, sticky state.
          state_reg <= ST_FAULT;
          fault_reg <= 1'b1;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc    = pc_reg;
  assign flush = flush_reg;
  assign fault = fault_reg;

  // Only bit 0 of the set-less-than result carries information.
  logic unused_cmp_lt;
  assign unused_cmp_lt = ^cmp_lt[31:1];

`ifdef BRANCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Branch statistics: index 0 counts taken, index 1 counts not-taken
  // conditional branches. Exactly one increments per counted cycle.
  // ---------------------------------------------------------------------------
  logic [1:0] cnt_inc;
  assign cnt_inc[0] = run_active && is_cond && cond_hit;
  assign cnt_inc[1] = run_active && is_cond && !cond_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [COUNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {COUNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + COUNT_W'(1);
        end
      end

      if (gi == 0) begin : g_taken
        assign taken_cnt = cnt_reg;
      end else begin : g_not_taken
        assign not_taken_cnt = cnt_reg;
      end
    end
  endgenerate
`else
  // Without statistics the conditional-class decode and counter width have
  // no consumer.
  logic               unused_is_cond;
  logic [COUNT_W-1:0] unused_count_w;
  assign unused_is_cond = is_cond;
  assign unused_count_w = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// -----------------------------------------------------------------------------
// Testbench for branch_pc_unit. A driver issues one instruction per cycle and
// pushes the expected responses, computed by a behavioural model, into two
// queues; independent monitors pop and compare the combinational taken output
// and the post-edge pc / flush / fault (and counters when BRANCH_STATS_EN).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef BRANCH_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [2:0]  br_type;
  logic [31:0] cmp_ne, cmp_lt, jr_target;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [31:0] pc, pc_plus4;
  logic        taken, flush, fault;
`ifdef BRANCH_STATS_EN
  logic [CW-1:0] taken_cnt, not_taken_cnt;
`endif

  always #5 clk = ~clk;

  branch_pc_unit #(.RESET_PC(RST_PC), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .br_type(br_type),
    .cmp_ne(cmp_ne), .cmp_lt(cmp_lt), .imm(imm), .jaddr(jaddr),
    .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4),
    .taken(taken), .flush(flush), .fault(fault)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    bit          flush;
    bit          fault;
    int          tcnt;
    int          ncnt;
  } exp_t;

  exp_t state_q[$];
  bit   taken_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 running, 1 squashing the instruction behind a redirect, 2 faulted.
  bit          m_known = 0;
  int          m_mode  = 0;
  logic [31:0] m_pc    = '0;
  int          m_tcnt  = 0;
  int          m_ncnt  = 0;

  function automatic bit cond_true(input logic [2:0] bt, input logic [31:0] ne, input logic [31:0] lt);
    case (bt)
      3'd1: return ne == 0;
      3'd2: return ne != 0;
      3'd3: return lt[0];
      3'd4: return !lt[0];
      3'd5, 3'd6, 3'd7: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] dest(input logic [2:0] bt, input logic [31:0] cur,
                                       input logic [15:0] im, input logic [25:0] ja,
                                       input logic [31:0] jt);
    int signed   words;
    logic [31:0] nxt;
    nxt   = cur + 32'd4;
    words = $signed(im);
    if (bt == 3'd7) return jt;
    if (bt == 3'd5 || bt == 3'd6) return (nxt & 32'hF000_0000) + (32'(ja) * 4);
    return nxt + 32'(words * 4);
  endfunction

  task automatic drive(input bit rst, input bit e, input logic [2:0] bt,
                       input logic [31:0] ne, input logic [31:0] lt,
                       input logic [15:0] im, input logic [25:0] ja,
                       input logic [31:0] jt);
    bit          hit;
    logic [31:0] tgt;
    exp_t        x;
    @(negedge clk);
    reset = rst; en = e; br_type = bt; cmp_ne = ne; cmp_lt = lt;
    imm = im; jaddr = ja; jr_target = jt;
    hit = cond_true(bt, ne, lt);
    if (m_known) taken_q.push_back(m_mode == 0 && e && hit);
    if (rst) begin
      m_known = 1; m_mode = 0; m_pc = RST_PC; m_tcnt = 0; m_ncnt = 0;
    end else if (m_known && m_mode != 2 && e) begin
      if (m_mode == 1) begin
        m_pc   = m_pc + 4;
        m_mode = 0;
      end else begin
        if (bt >= 3'd1 && bt <= 3'd4) begin
          if (hit) m_tcnt = (m_tcnt < CNT_MAX) ? m_tcnt + 1 : m_tcnt;
          else     m_ncnt = (m_ncnt < CNT_MAX) ? m_ncnt + 1 : m_ncnt;
        end
        if (hit) begin
          tgt = dest(bt, m_pc, im, ja, jt);
          if (tgt % 4 != 0) m_mode = 2;
          else begin m_pc = tgt; m_mode = 1; end
        end else begin
          m_pc = m_pc + 4;
        end
      end
    end
    if (m_known) begin
      x.pc = m_pc; x.flush = (m_mode == 1); x.fault = (m_mode == 2);
      x.tcnt = m_tcnt; x.ncnt = m_ncnt;
      state_q.push_back(x);
    end
  endtask

  task automatic nop(input bit e);
    drive(0, e, 3'd0, 32'd0, 32'd0, 16'd0, 26'd0, 32'd0);
  endtask

  // ---------------- monitors ----------------
  initial begin : mon_taken
    bit t;
    forever begin
      @(negedge clk);
      #2;
      if (taken_q.size() > 0) begin
        t = taken_q.pop_front();
        check("taken", {31'd0, taken}, {31'd0, t});
      end
    end
  end

  initial begin : mon_state
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (state_q.size() > 0) begin
        x = state_q.pop_front();
        check("pc", pc, x.pc);
        check("pc_plus4", pc_plus4, x.pc + 32'd4);
        check("flush", {31'd0, flush}, {31'd0, x.flush});
        check("fault", {31'd0, fault}, {31'd0, x.fault});
`ifdef BRANCH_STATS_EN
        check("taken_cnt", 32'(taken_cnt), 32'(x.tcnt));
        check("not_taken_cnt", 32'(not_taken_cnt), 32'(x.ncnt));
`endif
        $display("cycle %0d: pc=%h flush=%0d fault=%0d", cyc, pc, flush, fault);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; en = 0; br_type = 0; cmp_ne = 0; cmp_lt = 0;
    imm = 0; jaddr = 0; jr_target = 0;

    // Reset, then straight-line flow 0x0 -> 0x10
    drive(1, 1, 3'd0, 0, 0, 0, 0, 0);
    drive(1, 0, 3'd5, 0, 0, 0, 0, 0);
    repeat (4) nop(1);
    // beq taken at 0x10 -> 0x20, then a bne squashed during FLUSH -> 0x24
    drive(0, 1, 3'd1, 32'd0, 0, 16'h0003, 0, 0);
    drive(0, 1, 3'd2, 32'd5, 0, 16'h0040, 0, 0);
    // Reach 0x100, backward bne -> 0xF4, then blt with cmp_lt bit0 clear
    drive(0, 1, 3'd7, 0, 0, 0, 0, 32'h0000_00FC);
    nop(1);
    drive(0, 1, 3'd2, 32'h1, 0, 16'hFFFC, 0, 0);
    nop(1);
    drive(0, 1, 3'd3, 0, 32'hFFFF_FFFE, 16'h0010, 0, 0);
    drive(0, 1, 3'd4, 0, 32'h1, 16'h0010, 0, 0);
    // Reach 0x4000_0000, then j -> 0x4000_0100, jal
    drive(0, 1, 3'd7, 0, 0, 0, 0, 32'h3FFF_FFFC);
    nop(1);
    drive(0, 1, 3'd5, 0, 0, 0, 26'h0000040, 0);
    nop(1);
    drive(0, 1, 3'd6, 0, 0, 0, 26'h3FFFFFF, 0);
    nop(1);
    // Misaligned jr -> sticky fault, pc frozen
    drive(0, 1, 3'd7, 0, 0, 0, 0, 32'h0000_1002);
    repeat (5) drive(0, 1, 3'd5, 0, 0, 0, 26'h10, 0);
    drive(1, 1, 3'd0, 0, 0, 0, 0, 0);
    // Stall inside FLUSH, then reset while in FLUSH
    drive(0, 1, 3'd1, 32'd0, 0, 16'h0007, 0, 0);
    repeat (3) drive(0, 0, 3'd7, 0, 0, 0, 0, 32'h0000_0200);
    drive(1, 1, 3'd7, 0, 0, 0, 0, 32'h0000_0300);
    // Branch wrap-around through zero is legal
    drive(0, 1, 3'd1, 32'd0, 0, 16'h8000, 0, 0);
    nop(1);
    // Statistics: 5 taken beq (saturate), 1 not-taken bge, 1 j
    drive(1, 1, 3'd0, 0, 0, 0, 0, 0);
    repeat (5) begin
      drive(0, 1, 3'd1, 32'd0, 0, 16'h0001, 0, 0);
      nop(1);
    end
    drive(0, 1, 3'd4, 0, 32'h1, 16'h0001, 0, 0);
    drive(0, 1, 3'd5, 0, 0, 0, 26'h20, 0);
    nop(1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jt;
      jt = $urandom;
      if ($urandom_range(0, 9) != 0) jt[1:0] = 2'b00;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom,
            $urandom, 16'($urandom), 26'($urandom), jt);
    end

    // Drain, bounded
    for (int k = 0; k < 10 && (state_q.size() > 0 || taken_q.size() > 0); k++)
      @(posedge clk);
    #3;
    if (state_q.size() > 0 || taken_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d state and %0d taken expectations left, required 0",
               state_q.size(), taken_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
